// File: rtl/tile_pattern_scheduler.sv
// Shares one temporal-pattern accumulator bank across NUM_TILES tiles: collects 4 frames of
// binary tile values, then drains one pattern per tile. Optional macro: PATTERN_SKIP_STATIC_EN.
module tile_pattern_scheduler #(
  parameter int NUM_TILES  = 16,
  parameter int TILE_IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_sync,
  input  logic                  bin_valid,
  input  logic                  bin_in,
  output logic                  bin_ready,
  output logic                  pat_valid,
  input  logic                  pat_ready,
  output logic [TILE_IDX_W-1:0] pat_tile,
  output logic [3:0]            pat_id,
  output logic [1:0]            frame_slot,
  output logic                  overrun_err,
  input  logic                  err_clr
);

  localparam int PTR_W = TILE_IDX_W + 1;
  localparam logic [PTR_W-1:0]      TILES_P = PTR_W'(NUM_TILES);
  localparam logic [TILE_IDX_W-1:0] LAST_T  = TILE_IDX_W'(NUM_TILES - 1);

  typedef enum logic {S_COLLECT, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      tile_ptr_q, tile_ptr_d;
  logic [TILE_IDX_W-1:0] drain_ptr_q, drain_ptr_d;
  logic [1:0]            frame_slot_q, frame_slot_d;
  logic                  bin_ready_q, bin_ready_d;
  logic                  pat_valid_q, pat_valid_d;
  logic [TILE_IDX_W-1:0] pat_tile_q, pat_tile_d;
  logic [3:0]            pat_id_q, pat_id_d;
  logic                  overrun_err_q, overrun_err_d;
  logic [3:0]            acc_q [NUM_TILES];
  logic [3:0]            acc_d [NUM_TILES];

  logic                  beat;
  logic                  new_err;
  logic                  load_next;
  logic                  next_show;
  logic [TILE_IDX_W-1:0] next_tile;
  logic [3:0]            next_acc;

  always_comb begin
    state_d       = state_q;
    tile_ptr_d    = tile_ptr_q;
    drain_ptr_d   = drain_ptr_q;
    frame_slot_d  = frame_slot_q;
    bin_ready_d   = bin_ready_q;
    pat_valid_d   = pat_valid_q;
    pat_tile_d    = pat_tile_q;
    pat_id_d      = pat_id_q;
    for (int t = 0; t < NUM_TILES; t++) acc_d[t] = acc_q[t];
    beat      = 1'b0;
    new_err   = 1'b0;
    load_next = 1'b0;
    next_tile = '0;
    next_acc  = '0;
    next_show = 1'b0;

    case (state_q)
      S_COLLECT: begin
        beat = bin_valid & bin_ready_q;
        // a beat coinciding with frame_sync lands in the pre-sync slot
        if (beat) begin
          if (tile_ptr_q < TILES_P) begin
            for (int t = 0; t < NUM_TILES; t++)
              if (tile_ptr_q == PTR_W'(t)) acc_d[t][frame_slot_q] = bin_in;
            tile_ptr_d = tile_ptr_q + 1'b1;
          end else begin
            new_err = 1'b1;
          end
        end
        if (frame_sync) begin
          tile_ptr_d = '0;
          if (frame_slot_q != 2'd3) begin
            frame_slot_d = frame_slot_q + 2'd1;
          end else begin
            state_d     = S_DRAIN;
            bin_ready_d = 1'b0;
            drain_ptr_d = '0;
            load_next   = 1'b1;
            next_tile   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (frame_sync) new_err = 1'b1;
        // pat_valid low in DRAIN means the current tile is a skip cycle
        if (!pat_valid_q || pat_ready) begin
          for (int t = 0; t < NUM_TILES; t++)
            if (drain_ptr_q == TILE_IDX_W'(t)) acc_d[t] = '0;
          if (drain_ptr_q == LAST_T) begin
            state_d      = S_COLLECT;
            pat_valid_d  = 1'b0;
            frame_slot_d = 2'd0;
            bin_ready_d  = 1'b1;
          end else begin
            drain_ptr_d = drain_ptr_q + 1'b1;
            load_next   = 1'b1;
            next_tile   = drain_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase

    for (int t = 0; t < NUM_TILES; t++)
      if (next_tile == TILE_IDX_W'(t)) next_acc = acc_d[t];
`ifdef PATTERN_SKIP_STATIC_EN
    next_show = (next_acc != 4'h0) && (next_acc != 4'hF);
`else
    next_show = 1'b1;
`endif
    if (load_next) begin
      pat_valid_d = next_show;
      pat_tile_d  = next_tile;
      pat_id_d    = next_acc;
    end

    overrun_err_d = new_err | (overrun_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_COLLECT;
      tile_ptr_q    <= '0;
      drain_ptr_q   <= '0;
      frame_slot_q  <= 2'd0;
      bin_ready_q   <= 1'b1;
      pat_valid_q   <= 1'b0;
      pat_tile_q    <= '0;
      pat_id_q      <= '0;
      overrun_err_q <= 1'b0;
      for (int t = 0; t < NUM_TILES; t++) acc_q[t] <= '0;
    end else begin
      state_q       <= state_d;
      tile_ptr_q    <= tile_ptr_d;
      drain_ptr_q   <= drain_ptr_d;
      frame_slot_q  <= frame_slot_d;
      bin_ready_q   <= bin_ready_d;
      pat_valid_q   <= pat_valid_d;
      pat_tile_q    <= pat_tile_d;
      pat_id_q      <= pat_id_d;
      overrun_err_q <= overrun_err_d;
      for (int t = 0; t < NUM_TILES; t++) acc_q[t] <= acc_d[t];
    end
  end

  assign bin_ready   = bin_ready_q;
  assign pat_valid   = pat_valid_q;
  assign pat_tile    = pat_tile_q;
  assign pat_id      = pat_id_q;
  assign frame_slot  = frame_slot_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_tile_pattern_scheduler.sv
// Self-checking bench for tile_pattern_scheduler: random tile streams against a per-tile
// pattern model built from the frame/beat rules, with a cycle-level drain expectation.
module tb_tile_pattern_scheduler;
  localparam int NT = 16;
  localparam int W  = 4;

  logic clk = 1'b0, rst_n = 1'b0, frame_sync = 1'b0, bin_valid = 1'b0, bin_in = 1'b0;
  logic pat_ready = 1'b0, err_clr = 1'b0;
  logic bin_ready, pat_valid, overrun_err;
  logic [W-1:0] pat_tile;
  logic [3:0] pat_id;
  logic [1:0] frame_slot;

  int checks = 0, passes = 0;
  logic [3:0] model_acc [NT];
  bit model_err = 1'b0;
  bit stim [4][NT+4];

  tile_pattern_scheduler #(.NUM_TILES(NT), .TILE_IDX_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .frame_sync(frame_sync), .bin_valid(bin_valid),
    .bin_in(bin_in), .bin_ready(bin_ready), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_tile(pat_tile), .pat_id(pat_id), .frame_slot(frame_slot),
    .overrun_err(overrun_err), .err_clr(err_clr));

  always #5 clk = ~clk;

  function automatic bit is_static(input logic [3:0] a);
`ifdef PATTERN_SKIP_STATIC_EN
    return (a == 4'h0) || (a == 4'hF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_model();
    for (int t = 0; t < NT; t++) model_acc[t] = 4'h0;
  endtask

  task automatic random_stim();
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < NT + 4; i++) stim[f][i] = bit'($urandom_range(0, 1));
  endtask

  // Streams one frame; caller sits just after a negedge with inputs idle.
  task automatic send_frame(input int f, input int nbeats, input bit sync_on_last, input bit clr_on_last);
    int exp_slot;
    checks++; if (bin_ready !== 1'b1) $display("FAIL bin_ready_collect f=%0d got=%b want=1", f, bin_ready); else passes++;
    checks++; if (frame_slot !== 2'(f)) $display("FAIL frame_slot_start f=%0d got=%0d want=%0d", f, frame_slot, f); else passes++;
    for (int i = 0; i < nbeats; i++) begin
      bin_valid  = 1'b1;
      bin_in     = stim[f][i];
      frame_sync = sync_on_last && (i == nbeats - 1);
      err_clr    = clr_on_last && (i == nbeats - 1);
      if (i < NT) model_acc[i][f] = stim[f][i];
      if (i >= NT) model_err = 1'b1;
      else if (err_clr) model_err = 1'b0;
      @(negedge clk);
    end
    bin_valid = 1'b0;
    err_clr   = 1'b0;
    if (!sync_on_last) begin
      frame_sync = 1'b1;
      @(negedge clk);
    end
    frame_sync = 1'b0;
    exp_slot = (f < 3) ? f + 1 : 3;
    checks++; if (frame_slot !== 2'(exp_slot)) $display("FAIL frame_slot_after f=%0d got=%0d want=%0d", f, frame_slot, exp_slot); else passes++;
    checks++; if (overrun_err !== model_err) $display("FAIL overrun_after_frame f=%0d got=%b want=%b", f, overrun_err, model_err); else passes++;
  endtask

  task automatic send_round(input int nbeats, input bit sync_on_last);
    for (int f = 0; f < 4; f++) send_frame(f, nbeats, sync_on_last, 1'b0);
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_drain(input int mode, input int sync_at, input int stop_at);
    int cur = 0;
    int cyc = 0;
    logic rdy;
    while (cur < NT && cur != stop_at && cyc < 400) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = logic'($urandom_range(0, 1));
      endcase
      checks++; if (bin_ready !== 1'b0) $display("FAIL bin_ready_drain cyc=%0d got=%b want=0", cyc, bin_ready); else passes++;
      checks++; if (frame_slot !== 2'd3) $display("FAIL frame_slot_drain cyc=%0d got=%0d want=3", cyc, frame_slot); else passes++;
      if (is_static(model_acc[cur])) begin
        checks++; if (pat_valid !== 1'b0) $display("FAIL skip_valid tile=%0d got=%b want=0", cur, pat_valid); else passes++;
        cur++;
      end else begin
        checks++;
        if (pat_valid !== 1'b1 || pat_tile !== W'(cur) || pat_id !== model_acc[cur])
          $display("FAIL pattern cyc=%0d got v=%b tile=%0d id=%h want v=1 tile=%0d id=%h",
                   cyc, pat_valid, pat_tile, pat_id, cur, model_acc[cur]);
        else passes++;
        if (rdy) cur++;
      end
      pat_ready  = rdy;
      frame_sync = (cyc == sync_at);
      if (cyc == sync_at) model_err = 1'b1;
      @(negedge clk);
      cyc++;
    end
    pat_ready  = 1'b0;
    frame_sync = 1'b0;
    if (cyc >= 400) begin
      checks++;
      $display("FAIL drain_timeout cur=%0d got=timeout want=done", cur);
    end else if (cur == NT) begin
      checks++; if (bin_ready !== 1'b1) $display("FAIL bin_ready_end got=%b want=1", bin_ready); else passes++;
      checks++; if (pat_valid !== 1'b0) $display("FAIL pat_valid_end got=%b want=0", pat_valid); else passes++;
      checks++; if (frame_slot !== 2'd0) $display("FAIL frame_slot_end got=%0d want=0", frame_slot); else passes++;
      checks++; if (overrun_err !== model_err) $display("FAIL overrun_end got=%b want=%b", overrun_err, model_err); else passes++;
      clear_model();
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 1'b0;
    checks++; if (overrun_err !== 1'b0) $display("FAIL err_clr got=%b want=0", overrun_err); else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bin_ready !== 1'b1)   $display("FAIL rst_bin_ready got=%b want=1", bin_ready); else passes++;
    checks++; if (pat_valid !== 1'b0)   $display("FAIL rst_pat_valid got=%b want=0", pat_valid); else passes++;
    checks++; if (pat_tile !== '0)      $display("FAIL rst_pat_tile got=%0d want=0", pat_tile); else passes++;
    checks++; if (pat_id !== 4'h0)      $display("FAIL rst_pat_id got=%h want=0", pat_id); else passes++;
    checks++; if (frame_slot !== 2'd0)  $display("FAIL rst_frame_slot got=%0d want=0", frame_slot); else passes++;
    checks++; if (overrun_err !== 1'b0) $display("FAIL rst_overrun got=%b want=0", overrun_err); else passes++;
    rst_n = 1'b1;
    clear_model();
    model_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    for (int f = 0; f < 4; f++)
      for (int t = 0; t < NT + 4; t++) stim[f][t] = bit'((t >> f) & 1);
    send_round(NT, 1'b0);
    run_drain(0, -1, -1);
  endtask

  task automatic test_backpressure();
    random_stim();
    send_round(NT, 1'b0);
    run_drain(1, -1, -1);
  endtask

  task automatic test_overrun();
    random_stim();
    send_frame(0, NT + 1, 1'b0, 1'b1);
    pulse_err_clr();
    for (int f = 1; f < 4; f++) send_frame(f, NT, 1'b0, 1'b0);
    run_drain(2, -1, -1);
  endtask

  task automatic test_partial();
    for (int r = 0; r < 2; r++) begin
      for (int f = 0; f < 4; f++)
        for (int t = 0; t < NT + 4; t++) stim[f][t] = 1'b1;
      send_round(10, 1'b0);
      run_drain(0, -1, -1);
    end
  endtask

  task automatic test_sync_with_beat();
    random_stim();
    send_round(NT, 1'b1);
    run_drain(2, 3, -1);
    pulse_err_clr();
  endtask

  task automatic test_reset_mid_drain();
    random_stim();
    send_round(NT, 1'b0);
    run_drain(0, -1, 6);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pat_valid !== 1'b0)  $display("FAIL midrst_pat_valid got=%b want=0", pat_valid); else passes++;
    checks++; if (bin_ready !== 1'b1)  $display("FAIL midrst_bin_ready got=%b want=1", bin_ready); else passes++;
    checks++; if (frame_slot !== 2'd0) $display("FAIL midrst_frame_slot got=%0d want=0", frame_slot); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    model_err = 1'b0;
    @(negedge clk);
    random_stim();
    send_round(NT, 1'b0);
    run_drain(2, -1, -1);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_overrun();
    test_partial();
    test_sync_with_beat();
    test_reset_mid_drain();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  task automatic test_back_to_back_random();
    for (int r = 0; r < 3; r++) begin
      random_stim();
      send_round($urandom_range(8, NT), 1'b0);
      run_drain(2, -1, -1);
    end
  endtask

endmodule
